// File: rtl/fsm_cordic_ctrl_param_if.sv
// Handshake/control bundle between the CORDIC control FSM and its datapath.
//   master : the control FSM (drives LD_INIT, Begin_SUM, ADD_SUBT, SEL_OP, EN_REGx,
//            SHIFT, ITER_CNT, BUSY, ACK_FSM, ERR_TMO; samples start/mode/sign/ack)
//   slave  : the datapath / host side (mirror image of master)
// IW sets the width of SHIFT and ITER_CNT.
interface fsm_cordic_ctrl_param_if #(
   parameter int unsigned IW = 6
);
   logic          Begin_FSM;
   logic          RST_FSM;
   logic          HYP;
   logic          VECT;
   logic          SIGN_Y;
   logic          SIGN_Z;
   logic          ACK_ADD_SUBT;
   logic          LD_INIT;
   logic          Begin_SUM;
   logic          ADD_SUBT;
   logic [1:0]    SEL_OP;
   logic          EN_REGX;
   logic          EN_REGY;
   logic          EN_REGZ;
   logic [IW-1:0] SHIFT;
   logic [IW-1:0] ITER_CNT;
   logic          BUSY;
   logic          ACK_FSM;
   logic          ERR_TMO;

   modport master (
      input  Begin_FSM, RST_FSM, HYP, VECT, SIGN_Y, SIGN_Z, ACK_ADD_SUBT,
      output LD_INIT, Begin_SUM, ADD_SUBT, SEL_OP, EN_REGX, EN_REGY, EN_REGZ,
             SHIFT, ITER_CNT, BUSY, ACK_FSM, ERR_TMO
   );

   modport slave (
      output Begin_FSM, RST_FSM, HYP, VECT, SIGN_Y, SIGN_Z, ACK_ADD_SUBT,
      input  LD_INIT, Begin_SUM, ADD_SUBT, SEL_OP, EN_REGX, EN_REGY, EN_REGZ,
             SHIFT, ITER_CNT, BUSY, ACK_FSM, ERR_TMO
   );
endinterface

// File: rtl/fsm_cordic_ctrl_param.sv
// Control FSM for an iterative CORDIC datapath with one shared add/subtract unit.
// Each micro-rotation issues X, Y and Z updates through the Begin_SUM/ACK_ADD_SUBT
// handshake, then advances its own shift and iteration counters (with hyperbolic
// repeat iterations at shift 4, 13, 40, ...). A missing adder ack times out to ERR.
// Ports:
//   CLK  : system clock
//   RST  : synchronous active-high reset, clears state and all outputs
//   bus  : fsm_cordic_ctrl_param_if.master (start/mode/sign/ack in, datapath
//          controls, SHIFT, ITER_CNT and status flags out; all outputs registered)
module fsm_cordic_ctrl_param #(
   parameter int unsigned ITERS   = 16,
   parameter int unsigned IW      = 6,
   parameter int unsigned TMO_CYC = 64
) (
   input  logic                    CLK,
   input  logic                    RST,
   fsm_cordic_ctrl_param_if.master bus
);

   localparam int unsigned   TW      = $clog2(TMO_CYC);
   localparam int unsigned   RW      = IW + 2;
   localparam logic [TW-1:0] TmoLast = TW'(TMO_CYC - 1);
   localparam logic [IW:0]   ItersL  = (IW+1)'(ITERS);
   localparam logic [1:0]    SelX    = 2'b00;
   localparam logic [1:0]    SelY    = 2'b01;
   localparam logic [1:0]    SelZ    = 2'b10;

   typedef enum logic [3:0] {
      StIdle, StInit, StDir, StXs, StXw, StYs, StYw, StZs, StZw, StStep, StDone, StErr
   } state_e;

   state_e         state_q;
   logic           hyp_q;
   logic           vect_q;
   logic           d_q;         // 1 = sigma +1, fixed for the whole micro-rotation
   logic           rep_flag_q;  // current shift value has already been repeated
   logic [RW-1:0]  rep_pt_q;    // next hyperbolic repeat point (4, 13, 40, ...)
   logic [TW-1:0]  tmo_q;

   logic           dir_d;
   logic           clr_fsm;
   logic [IW:0]    iter_inc;
   logic           at_rep_pt;

   always_comb begin
      dir_d     = vect_q ? bus.SIGN_Y : ~bus.SIGN_Z;
      clr_fsm   = ((state_q == StDone) || (state_q == StErr)) && bus.RST_FSM;
      iter_inc  = {1'b0, bus.ITER_CNT} + (IW+1)'(1);
      at_rep_pt = ({2'b00, bus.SHIFT} == rep_pt_q);
   end

   always_ff @(posedge CLK) begin
      if (RST || clr_fsm) begin
         state_q       <= StIdle;
         hyp_q         <= 1'b0;
         vect_q        <= 1'b0;
         d_q           <= 1'b0;
         rep_flag_q    <= 1'b0;
         rep_pt_q      <= '0;
         tmo_q         <= '0;
         bus.LD_INIT   <= 1'b0;
         bus.Begin_SUM <= 1'b0;
         bus.ADD_SUBT  <= 1'b0;
         bus.SEL_OP    <= SelX;
         bus.EN_REGX   <= 1'b0;
         bus.EN_REGY   <= 1'b0;
         bus.EN_REGZ   <= 1'b0;
         bus.SHIFT     <= '0;
         bus.ITER_CNT  <= '0;
         bus.BUSY      <= 1'b0;
         bus.ACK_FSM   <= 1'b0;
         bus.ERR_TMO   <= 1'b0;
      end else begin
         // Single-cycle pulses default low.
         bus.LD_INIT   <= 1'b0;
         bus.Begin_SUM <= 1'b0;
         bus.EN_REGX   <= 1'b0;
         bus.EN_REGY   <= 1'b0;
         bus.EN_REGZ   <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (bus.Begin_FSM) begin
                  hyp_q        <= bus.HYP;
                  vect_q       <= bus.VECT;
                  bus.SHIFT    <= bus.HYP ? IW'(1) : '0;
                  bus.ITER_CNT <= '0;
                  rep_pt_q     <= RW'(4);
                  rep_flag_q   <= 1'b0;
                  bus.LD_INIT  <= 1'b1;
                  bus.BUSY     <= 1'b1;
                  state_q      <= StInit;
               end
            end
            StInit: state_q <= StDir;
            StDir: begin
               d_q           <= dir_d;
               bus.SEL_OP    <= SelX;
               bus.ADD_SUBT  <= hyp_q ? ~dir_d : dir_d;
               bus.Begin_SUM <= 1'b1;
               state_q       <= StXs;
            end
            StXs: begin
               tmo_q   <= '0;
               state_q <= StXw;
            end
            StYs: begin
               tmo_q   <= '0;
               state_q <= StYw;
            end
            StZs: begin
               tmo_q   <= '0;
               state_q <= StZw;
            end
            StXw, StYw, StZw: begin
               if (bus.ACK_ADD_SUBT) begin
                  if (state_q == StXw) begin
                     bus.EN_REGX   <= 1'b1;
                     bus.SEL_OP    <= SelY;
                     bus.ADD_SUBT  <= ~d_q;
                     bus.Begin_SUM <= 1'b1;
                     state_q       <= StYs;
                  end else if (state_q == StYw) begin
                     bus.EN_REGY   <= 1'b1;
                     bus.SEL_OP    <= SelZ;
                     bus.ADD_SUBT  <= d_q;
                     bus.Begin_SUM <= 1'b1;
                     state_q       <= StZs;
                  end else begin
                     bus.EN_REGZ <= 1'b1;
                     state_q     <= StStep;
                  end
               end else if (tmo_q == TmoLast) begin
                  bus.SEL_OP   <= SelX;
                  bus.ADD_SUBT <= 1'b0;
                  bus.BUSY     <= 1'b0;
                  bus.ERR_TMO  <= 1'b1;
                  state_q      <= StErr;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            StStep: begin
               bus.ITER_CNT <= iter_inc[IW-1:0];
               if (hyp_q && at_rep_pt && !rep_flag_q) begin
                  // Hyperbolic convergence needs this shift executed twice.
                  rep_flag_q <= 1'b1;
               end else begin
                  rep_flag_q <= 1'b0;
                  bus.SHIFT  <= bus.SHIFT + IW'(1);
                  if (at_rep_pt) begin
                     rep_pt_q <= rep_pt_q + (rep_pt_q << 1) + RW'(1);
                  end
               end
               if (iter_inc == ItersL) begin
                  bus.BUSY    <= 1'b0;
                  bus.ACK_FSM <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  state_q <= StDir;
               end
            end
            StDone: state_q <= StDone;
            StErr:  state_q <= StErr;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_cordic_ctrl_param.sv
module tb_fsm_cordic_ctrl_param;

   localparam int unsigned ITERS   = 16;
   localparam int unsigned IW      = 6;
   localparam int unsigned TMO_CYC = 64;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   fsm_cordic_ctrl_param_if #(.IW(IW)) bus ();

   fsm_cordic_ctrl_param #(
      .ITERS   (ITERS),
      .IW      (IW),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       hyp;
      logic       vect;
      logic       sy;
      logic       sz;
      logic [2:0] exp_zyx;
   } vec_t;

   int n_tot = 0;
   int n_bad = 0;

   // Adder model and activity logs, evaluated away from the active edge.
   logic       ack_prev = 1'b0;
   logic       blk_y    = 1'b0;
   int         nb, nx, ny, nz, nxs;
   logic [2:0] add_log   [64];
   int         shift_log [64];
   int         sel_seq   [4];

   logic [22:0] outs_all;
   assign outs_all = {bus.LD_INIT, bus.Begin_SUM, bus.ADD_SUBT, bus.SEL_OP, bus.EN_REGX,
                      bus.EN_REGY, bus.EN_REGZ, bus.SHIFT, bus.ITER_CNT, bus.BUSY,
                      bus.ACK_FSM, bus.ERR_TMO};

   int exp_sh [16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

   always @(negedge CLK) begin
      bus.ACK_ADD_SUBT = ack_prev && !(blk_y && bus.SEL_OP == 2'b01);
      ack_prev = bus.Begin_SUM;
      if (bus.EN_REGX) nx++;
      if (bus.EN_REGY) ny++;
      if (bus.EN_REGZ) nz++;
      if (bus.Begin_SUM) begin
         if (nb < 4) sel_seq[nb] = int'(bus.SEL_OP);
         nb++;
         if (bus.SEL_OP == 2'b00) begin
            if (nxs < 64) begin
               shift_log[nxs] = int'(bus.SHIFT);
               add_log[nxs]   = 3'b000;
               add_log[nxs][0] = bus.ADD_SUBT;
            end
            nxs++;
         end else if (nxs > 0 && nxs <= 64 && bus.SEL_OP != 2'b11) begin
            add_log[nxs-1][int'(bus.SEL_OP)] = bus.ADD_SUBT;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_logs();
      nb = 0; nx = 0; ny = 0; nz = 0; nxs = 0;
      for (int i = 0; i < 4; i++) sel_seq[i] = -1;
   endtask

   task automatic run_to_done(input bit poke_busy, output int cyc);
      cyc = 0;
      bus.Begin_FSM = 1'b1;
      do begin
         tick();
         cyc++;
         bus.Begin_FSM = poke_busy && (cyc == 20);
      end while (!bus.ACK_FSM && !bus.ERR_TMO && cyc < 400);
      bus.Begin_FSM = 1'b0;
   endtask

   task automatic fsm_clear();
      bus.RST_FSM = 1'b1;
      tick();
      bus.RST_FSM = 1'b0;
   endtask

   initial begin
      vec_t vecs [8];
      int   cyc;
      int   n;
      bit   seen;

      vecs[0] = '{hyp:1'b0, vect:1'b0, sy:1'b0, sz:1'b0, exp_zyx:3'b101};
      vecs[1] = '{hyp:1'b0, vect:1'b0, sy:1'b1, sz:1'b1, exp_zyx:3'b010};
      vecs[2] = '{hyp:1'b1, vect:1'b0, sy:1'b0, sz:1'b0, exp_zyx:3'b100};
      vecs[3] = '{hyp:1'b1, vect:1'b0, sy:1'b0, sz:1'b1, exp_zyx:3'b011};
      vecs[4] = '{hyp:1'b0, vect:1'b1, sy:1'b1, sz:1'b1, exp_zyx:3'b101};
      vecs[5] = '{hyp:1'b0, vect:1'b1, sy:1'b0, sz:1'b0, exp_zyx:3'b010};
      vecs[6] = '{hyp:1'b1, vect:1'b1, sy:1'b1, sz:1'b0, exp_zyx:3'b100};
      vecs[7] = '{hyp:1'b1, vect:1'b1, sy:1'b0, sz:1'b1, exp_zyx:3'b011};

      bus.Begin_FSM = 1'b0; bus.RST_FSM = 1'b0; bus.HYP = 1'b0; bus.VECT = 1'b0;
      bus.SIGN_Y = 1'b0; bus.SIGN_Z = 1'b0;
      clear_logs();
      repeat (3) tick();
      chk("reset_outputs", int'(outs_all), 0);
      RST = 1'b0;
      tick();
      chk("idle_outputs", int'(outs_all), 0);

      // First micro-rotation direction/operation for each mode combination.
      for (int v = 0; v < 8; v++) begin
         bus.HYP = vecs[v].hyp; bus.VECT = vecs[v].vect;
         bus.SIGN_Y = vecs[v].sy; bus.SIGN_Z = vecs[v].sz;
         clear_logs();
         bus.Begin_FSM = 1'b1;
         tick();
         bus.Begin_FSM = 1'b0;
         chk("vec_ld_init", int'(bus.LD_INIT), 1);
         n = 0;
         while (nb < 3 && n < 30) begin tick(); n++; end
         chk("vec_zyx", int'(add_log[0]), int'(vecs[v].exp_zyx));
         chk("vec_sel0", sel_seq[0], 0);
         chk("vec_sel1", sel_seq[1], 1);
         chk("vec_sel2", sel_seq[2], 2);
         chk("vec_shift0", shift_log[0], int'(vecs[v].hyp));
         RST = 1'b1; tick(); RST = 1'b0;
      end

      // Circular rotation, with a Begin_FSM poke while busy.
      bus.HYP = 1'b0; bus.VECT = 1'b0; bus.SIGN_Z = 1'b0;
      clear_logs();
      run_to_done(1'b1, cyc);
      chk("circ_latency", cyc, 130);
      chk("circ_begin_sum", nb, 48);
      chk("circ_en_x", nx, 16);
      chk("circ_en_y", ny, 16);
      chk("circ_en_z", nz, 16);
      chk("circ_shift_end", int'(bus.SHIFT), 16);
      chk("circ_iter_end", int'(bus.ITER_CNT), 16);
      chk("circ_busy_done", int'(bus.BUSY), 0);
      chk("circ_last_shift", shift_log[15], 15);
      // Begin_FSM in DONE is ignored.
      bus.Begin_FSM = 1'b1;
      repeat (3) tick();
      bus.Begin_FSM = 1'b0;
      tick();
      chk("done_hold_ack", int'(bus.ACK_FSM), 1);
      chk("done_hold_iter", int'(bus.ITER_CNT), 16);
      chk("done_no_restart", nb, 48);
      fsm_clear();
      chk("done_clear", int'(outs_all), 0);

      // Hyperbolic: repeat iterations at shift 4 and 13.
      bus.HYP = 1'b1;
      clear_logs();
      run_to_done(1'b0, cyc);
      chk("hyp_latency", cyc, 130);
      for (int i = 0; i < 16; i++) chk($sformatf("hyp_shift[%0d]", i), shift_log[i], exp_sh[i]);
      chk("hyp_iter_end", int'(bus.ITER_CNT), 16);
      chk("hyp_shift_end", int'(bus.SHIFT), 15);
      fsm_clear();

      // Vectoring with SIGN_Y flipped mid-iteration 2: takes effect from iteration 3.
      bus.HYP = 1'b0; bus.VECT = 1'b1; bus.SIGN_Y = 1'b1; bus.SIGN_Z = 1'b1;
      clear_logs();
      bus.Begin_FSM = 1'b1;
      tick();
      bus.Begin_FSM = 1'b0;
      n = 0;
      while (nxs < 3 && n < 100) begin tick(); n++; end
      bus.SIGN_Y = 1'b0;
      while (!bus.ACK_FSM && n < 400) begin tick(); n++; end
      chk("vect_done", int'(bus.ACK_FSM), 1);
      for (int i = 0; i < 16; i++)
         chk($sformatf("vect_zyx[%0d]", i), int'(add_log[i]), (i < 3) ? 5 : 2);
      fsm_clear();

      // Adder never acks the Y update: timeout 64 cycles after YW entry.
      bus.VECT = 1'b0; bus.SIGN_Z = 1'b0;
      blk_y = 1'b1;
      clear_logs();
      bus.Begin_FSM = 1'b1;
      tick();
      bus.Begin_FSM = 1'b0;
      n = 0;
      while (!(bus.Begin_SUM && bus.SEL_OP == 2'b01) && n < 30) begin tick(); n++; end
      chk("tmo_reach_ys", int'(bus.Begin_SUM && bus.SEL_OP == 2'b01), 1);
      tick();
      n = 0; seen = 1'b0;
      while (!bus.ERR_TMO && n < 200) begin
         tick(); n++;
         if (bus.EN_REGY) seen = 1'b1;
      end
      chk("tmo_cycles", n, 64);
      chk("tmo_no_en_y", int'(seen), 0);
      chk("tmo_busy", int'(bus.BUSY), 0);
      tick();
      chk("tmo_err_held", int'(bus.ERR_TMO), 1);
      fsm_clear();
      chk("tmo_clear", int'(outs_all), 0);
      blk_y = 1'b0;

      // Synchronous reset during iteration 7 (ZW), then a clean restart.
      clear_logs();
      bus.Begin_FSM = 1'b1;
      tick();
      bus.Begin_FSM = 1'b0;
      n = 0;
      while (!(bus.Begin_SUM && bus.SEL_OP == 2'b10 && nxs == 8) && n < 200) begin
         tick(); n++;
      end
      chk("rst_reach_zs7", int'(bus.ITER_CNT), 7);
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("rst_mid_outputs", int'(outs_all), 0);
      tick();
      chk("rst_stays_idle", int'(outs_all), 0);
      clear_logs();
      run_to_done(1'b0, cyc);
      chk("restart_latency", cyc, 130);
      chk("restart_en_x", nx, 16);
      chk("restart_shift0", shift_log[0], 0);
      fsm_clear();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
